seq_slice_adder: RTL and testbench

- Multi-cycle WIDTH-bit add/subtract unit built from SLICE-bit carry-propagating steps.
- Processes one slice per clock, LSB slice first.
- Intended for the 32-bit datapath, where area matters more than latency, and as the sequential successor to the 1-bit full-adder cell.
- Produces sum, carry-out and signed-overflow, using a start/done handshake.

---
 rtl/seq_slice_adder.sv | 140 ++++++++++++++
 tb/tb_seq_slice_adder.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_slice_adder.sv
// Multi-cycle add/subtract unit: one SLICE-bit carry-propagating step per clock, LSB slice first.
// Optional registered zero flag on z when SEQ_SLICE_ADDER_ZERO_FLAG_EN is defined.
module seq_slice_adder #(
  parameter int WIDTH = 32,
  parameter int SLICE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic             cout,
  output logic             ovf
`ifdef SEQ_SLICE_ADDER_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  // state | meaning
  // IDLE  | waiting for start, ready=1
  // RUN   | one slice per cycle, ready=0
  // DONE  | result valid, done pulse, ready=1
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_slice
      $error("seq_slice_adder: SLICE must divide WIDTH exactly");
    end
  endgenerate

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, z_q, z_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SLICE:0]   slice_sum;
  logic [WIDTH-1:0] res_next;
  logic             msb_cin;
  logic             last_step;

  assign slice_sum = {1'b0, a_q[SLICE-1:0]} + {1'b0, b_q[SLICE-1:0]} + {{SLICE{1'b0}}, carry_q};
  // Carry into the slice's top bit, recovered from that bit's sum and operands.
  assign msb_cin   = slice_sum[SLICE-1] ^ a_q[SLICE-1] ^ b_q[SLICE-1];
  assign res_next  = WIDTH'({slice_sum[SLICE-1:0], res_q} >> SLICE);
  assign last_step = (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = sub;
          cnt_d   = '0;
          state_d = S_RUN;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_d     = a_q >> SLICE;
        b_d     = b_q >> SLICE;
        res_d   = res_next;
        carry_d = slice_sum[SLICE];
        cnt_d   = cnt_q + CW'(1);
        if (last_step) begin
          z_d     = res_next;
          cout_d  = slice_sum[SLICE];
          ovf_d   = msb_cin ^ slice_sum[SLICE];
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      z_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready = (state_q != S_RUN);
  assign done  = (state_q == S_DONE);
  assign z     = z_q;
  assign cout  = cout_q;
  assign ovf   = ovf_q;

`ifdef SEQ_SLICE_ADDER_ZERO_FLAG_EN
  logic zero_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      zero_q <= 1'b1;
    end else if (state_q == S_RUN && last_step) begin
      zero_q <= (res_next == '0);
    end
  end

  assign zero = zero_q;
`endif

endmodule

// File: tb/tb_seq_slice_adder.sv
// Self-checking bench for seq_slice_adder: 32/1 main instance, 4/4 exhaustive, 32/4 randomized.
module tb_seq_slice_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, sub;
  logic [31:0] a, b, z;
  logic        ready, done, cout, ovf;
  logic        s_start, s_sub, s_ready, s_done, s_cout, s_ovf;
  logic [3:0]  s_a, s_b, s_z;
  logic        m_start, m_sub, m_ready, m_done, m_cout, m_ovf;
  logic [31:0] m_a, m_b, m_z;
`ifdef SEQ_SLICE_ADDER_ZERO_FLAG_EN
  logic        zero, s_zero, m_zero;
`endif

  int errors = 0;
  int checks = 0;

  seq_slice_adder #(.WIDTH(32), .SLICE(1)) dut (
    .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b),
    .ready(ready), .done(done), .z(z), .cout(cout), .ovf(ovf)
`ifdef SEQ_SLICE_ADDER_ZERO_FLAG_EN
    , .zero(zero)
`endif
  );

  seq_slice_adder #(.WIDTH(4), .SLICE(4)) dut_s (
    .clk(clk), .reset(reset), .start(s_start), .sub(s_sub), .a(s_a), .b(s_b),
    .ready(s_ready), .done(s_done), .z(s_z), .cout(s_cout), .ovf(s_ovf)
`ifdef SEQ_SLICE_ADDER_ZERO_FLAG_EN
    , .zero(s_zero)
`endif
  );

  seq_slice_adder #(.WIDTH(32), .SLICE(4)) dut_m (
    .clk(clk), .reset(reset), .start(m_start), .sub(m_sub), .a(m_a), .b(m_b),
    .ready(m_ready), .done(m_done), .z(m_z), .cout(m_cout), .ovf(m_ovf)
`ifdef SEQ_SLICE_ADDER_ZERO_FLAG_EN
    , .zero(m_zero)
`endif
  );

  // Reference: modular add of a and (b inverted when subtracting) plus sub; overflow from signed range.
  function automatic void model(input int w, input longint ua, input longint ub, input bit s,
                                output longint ez, output bit ec, output bit eo);
    longint mask, half, bx, full, sa, sb, ss;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    bx   = (ub ^ (s ? mask : longint'(0))) & mask;
    full = ua + bx + longint'(s);
    ez   = full & mask;
    ec   = ((full >> w) & 1) != 0;
    sa   = (ua >= half) ? ua - (mask + 1) : ua;
    sb   = (bx >= half) ? bx - (mask + 1) : bx;
    ss   = sa + sb + longint'(s);
    eo   = (ss >= half) || (ss < -half);
  endfunction

  // Called at a negedge; returns at the negedge where done is seen (or the budget runs out).
  task automatic drive_main(input logic [31:0] ia, input logic [31:0] ib, input bit is,
                            input int inject, output int lat, output bit bad);
    logic [31:0] z0;
    z0 = z;
    a = ia; b = ib; sub = is; start = 1'b1;
    lat = 0; bad = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      start = (lat == inject);
      if (lat == inject) begin
        a = ~ia; b = ib + 32'd1; sub = ~is;
      end
      if (!done && (ready || z !== z0)) bad = 1'b1;
    end while (!done && lat < 100);
    start = 1'b0;
  endtask

  task automatic drive_s(input logic [3:0] ia, input logic [3:0] ib, input bit is, output int lat);
    s_a = ia; s_b = ib; s_sub = is; s_start = 1'b1; lat = 0;
    do begin
      @(negedge clk);
      lat++;
      s_start = 1'b0;
    end while (!s_done && lat < 20);
  endtask

  task automatic drive_m(input logic [31:0] ia, input logic [31:0] ib, input bit is, output int lat);
    m_a = ia; m_b = ib; m_sub = is; m_start = 1'b1; lat = 0;
    do begin
      @(negedge clk);
      lat++;
      m_start = 1'b0;
    end while (!m_done && lat < 40);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; a = 32'd9; b = 32'd9; sub = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ready, done, z, cout, ovf} !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_main: got ready=%b done=%b z=%h cout=%b ovf=%b, want 1 0 0 0 0",
               ready, done, z, cout, ovf);
    end
    checks++;
    if ({s_ready, s_done, s_z, m_ready, m_done, m_z} !== {1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL reset_others: got s=%b%b%h m=%b%b%h, want 1 0 0 / 1 0 0",
               s_ready, s_done, s_z, m_ready, m_done, m_z);
    end
`ifdef SEQ_SLICE_ADDER_ZERO_FLAG_EN
    checks++;
    if (zero !== 1'b1) begin
      errors++;
      $display("FAIL reset_zero: got %b want 1", zero);
    end
`endif
    reset = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_beats_start: got ready=%b done=%b want 1 0", ready, done);
    end
  endtask

  task automatic test_directed();
    logic [31:0] ta[5] = '{32'd5, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'd3, 32'd5};
    logic [31:0] tb[5] = '{32'd7, 32'd1, 32'd1, 32'd5, 32'd3};
    bit          ts[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] ez[5] = '{32'd12, 32'h80000000, 32'd0, 32'hFFFFFFFE, 32'd2};
    bit          ec[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    bit          eo[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    int lat;
    bit bad;
    for (int i = 0; i < 5; i++) begin
      drive_main(ta[i], tb[i], ts[i], 0, lat, bad);
      checks++;
      if (lat != 33 || bad) begin
        errors++;
        $display("FAIL directed_timing[%0d]: got latency=%0d busy_violation=%b, want 33 0", i, lat, bad);
      end
      checks++;
      if ({z, cout, ovf} !== {ez[i], ec[i], eo[i]}) begin
        errors++;
        $display("FAIL directed_result[%0d]: got z=%h cout=%b ovf=%b, want z=%h cout=%b ovf=%b",
                 i, z, cout, ovf, ez[i], ec[i], eo[i]);
      end
`ifdef SEQ_SLICE_ADDER_ZERO_FLAG_EN
      checks++;
      if (zero !== (ez[i] == 32'd0)) begin
        errors++;
        $display("FAIL directed_zero[%0d]: got %b want %b", i, zero, ez[i] == 32'd0);
      end
`endif
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || ready !== 1'b1 || z !== ez[i]) begin
        errors++;
        $display("FAIL directed_hold[%0d]: got done=%b ready=%b z=%h, want 0 1 %h", i, done, ready, z, ez[i]);
      end
    end
  endtask

  task automatic test_ignore_start();
    longint ez;
    bit ec, eo, bad;
    int lat;
    model(32, longint'(32'h1234_5678), longint'(32'h0FED_CBA9), 1'b1, ez, ec, eo);
    drive_main(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 5, lat, bad);
    checks++;
    if (lat != 33 || bad || {z, cout, ovf} !== {ez[31:0], ec, eo}) begin
      errors++;
      $display("FAIL ignore_start: got lat=%0d bad=%b z=%h c=%b o=%b, want 33 0 %h %b %b",
               lat, bad, z, cout, ovf, ez[31:0], ec, eo);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] xa[3] = '{32'hDEAD_BEEF, 32'h8000_0000, 32'h0000_0010};
    logic [31:0] xb[3] = '{32'h1111_1111, 32'h8000_0000, 32'h0000_0020};
    bit          xs[3] = '{1'b0, 1'b0, 1'b1};
    longint ez;
    bit ec, eo, bad;
    int lat;
    for (int i = 0; i < 3; i++) begin
      model(32, longint'(xa[i]), longint'(xb[i]), xs[i], ez, ec, eo);
      drive_main(xa[i], xb[i], xs[i], 0, lat, bad);
      checks++;
      if (lat != 33 || bad || {z, cout, ovf} !== {ez[31:0], ec, eo}) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got lat=%0d bad=%b z=%h c=%b o=%b, want 33 0 %h %b %b",
                 i, lat, bad, z, cout, ovf, ez[31:0], ec, eo);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    bit pulsed;
    int lat;
    bit bad;
    a = 32'h0000_00FF; b = 32'h0000_0001; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({ready, done, z, cout, ovf} !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_run: got ready=%b done=%b z=%h cout=%b ovf=%b, want 1 0 0 0 0",
               ready, done, z, cout, ovf);
    end
    reset = 1'b0;
    pulsed = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) pulsed = 1'b1;
    end
    checks++;
    if (pulsed) begin
      errors++;
      $display("FAIL aborted_done: got done pulse after reset, want none");
    end
    drive_main(32'd100, 32'd23, 1'b0, 0, lat, bad);
    checks++;
    if (lat != 33 || bad || {z, cout, ovf} !== {32'd123, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL after_reset_op: got lat=%0d z=%h c=%b o=%b, want 33 0000007b 0 0", lat, z, cout, ovf);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] ra, rb;
    bit rs, ec, eo, bad;
    longint ez;
    int lat;
    for (int i = 0; i < 15; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(1));
      if (i % 5 == 0) rb = ra;
      model(32, longint'(ra), longint'(rb), rs, ez, ec, eo);
      drive_main(ra, rb, rs, 0, lat, bad);
      checks++;
      if (lat != 33 || bad || {z, cout, ovf} !== {ez[31:0], ec, eo}) begin
        errors++;
        $display("FAIL random[%0d]: a=%h b=%h sub=%b got lat=%0d z=%h c=%b o=%b, want 33 %h %b %b",
                 i, ra, rb, rs, lat, z, cout, ovf, ez[31:0], ec, eo);
      end
      if ($urandom_range(1) == 1) @(negedge clk);
    end
  endtask

  task automatic test_exhaustive_slice4();
    longint ez;
    bit ec, eo;
    int lat;
    for (int s = 0; s < 2; s++)
      for (int ia = 0; ia < 16; ia++)
        for (int ib = 0; ib < 16; ib++) begin
          model(4, longint'(ia), longint'(ib), s[0], ez, ec, eo);
          drive_s(4'(ia), 4'(ib), s[0], lat);
          checks++;
          if (lat != 2 || {s_z, s_cout, s_ovf} !== {ez[3:0], ec, eo}) begin
            errors++;
            $display("FAIL exhaustive4: a=%0d b=%0d sub=%0d got lat=%0d z=%h c=%b o=%b, want 2 %h %b %b",
                     ia, ib, s, lat, s_z, s_cout, s_ovf, ez[3:0], ec, eo);
          end
        end
    s_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random_slice4();
    logic [31:0] ra, rb;
    bit rs, ec, eo;
    longint ez;
    int lat;
    for (int i = 0; i < 20; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(1));
      model(32, longint'(ra), longint'(rb), rs, ez, ec, eo);
      drive_m(ra, rb, rs, lat);
      checks++;
      if (lat != 9 || {m_z, m_cout, m_ovf} !== {ez[31:0], ec, eo}) begin
        errors++;
        $display("FAIL random_slice4[%0d]: a=%h b=%h sub=%b got lat=%0d z=%h c=%b o=%b, want 9 %h %b %b",
                 i, ra, rb, rs, lat, m_z, m_cout, m_ovf, ez[31:0], ec, eo);
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    s_start = 1'b0; s_sub = 1'b0; s_a = '0; s_b = '0;
    m_start = 1'b0; m_sub = 1'b0; m_a = '0; m_b = '0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    test_exhaustive_slice4();
    test_random_slice4();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
